trees_job_scheduler: RTL and testbench
======================================

// Module: trees_job_scheduler
// PURPOSE
// - Shares one trees_ping_pong inference engine between N_REQ requesters (host DMA channels).
// - Round-robin arbitrates burst jobs, sequences the accelerator's start/done and holds ownership
//   until the owner acknowledges completion, so its prediction buffer is read out before reuse.
// - acc_owner/acc_busy steer the feature-load and prediction-read muxes in the accelerator wrapper.
// PARAMETERS
// - N_REQ          4      number of requesters (>=2)
// - MAX_BURST      5000   max samples per job; must match the accelerator
// - TIMEOUT_CYCLES 2**20  watchdog limit in RUN (used only with TREES_SCHED_TIMEOUT_EN)
// - BL_W = $clog2(MAX_BURST)+1 (localparam), ID_W = $clog2(N_REQ) (localparam)
// PORTS
// - clk            in   1            clock
// - rst            in   1            synchronous, active-high reset
// - req_valid      in   N_REQ        job request per requester, level
// - req_burst_len  in   N_REQ*BL_W   job length per requester, packed [i*BL_W +: BL_W]
// - req_ready      out  N_REQ        one-cycle accept pulse to the granted requester
// - cmp_valid      out  N_REQ        completion to owner, held until cmp_ack
// - cmp_err        out  1            error flag, valid while any cmp_valid bit is high
// - cmp_ack        in   N_REQ        owner acknowledge (predictions consumed)
// - acc_start      out  1            one-cycle start pulse to accelerator
// - acc_burst_len  out  BL_W-1       burst length driven to accelerator
// - acc_done       in   1            accelerator done pulse
// - acc_busy       out  1            1 when state != S_IDLE
// - acc_owner      out  ID_W         current owner index; 0 when idle
// BEHAVIOUR
// - Reset: all outputs 0; state S_IDLE; rr_last = N_REQ-1 (req 0 wins first); watchdog count 0.
//   Reset mid-job abandons the job silently; no cmp_valid is issued.
// - FSM states: S_IDLE, S_GRANT, S_START, S_RUN, S_CPL.
// - S_IDLE: arbitrate only here. Pick the first i with req_valid[i], scanning from rr_last+1 mod N_REQ.
//   Latch owner=i and len=req_burst_len[i], then go to S_GRANT. No request: stay.
// - S_GRANT: req_ready[owner]=1 for exactly this cycle.
//   - len==0: go to S_CPL, err=0. The accelerator is not started.
//   - len>MAX_BURST: go to S_CPL, err=1. The accelerator is not started.
//   - Otherwise: go to S_START.
// - S_START: acc_start=1 for one cycle, then go to S_RUN.
//   acc_burst_len = len, stable from S_GRANT until leaving S_RUN.
// - S_RUN: on acc_done go to S_CPL with err=0. acc_done seen in any other state is ignored.
// - S_CPL: cmp_valid[owner]=1 and cmp_err=err, both held.
//   - On cmp_ack[owner]: rr_last<=owner, go to S_IDLE; cmp_valid drops the next cycle.
//   - cmp_ack on non-owner bits is ignored.
// - Latency: req sampled at cycle t -> req_ready at t+1 -> acc_start at t+2.
//   cmp_ack at cycle c -> the earliest next grant (req_ready) is at c+2.
// - Requesters hold req_valid/req_burst_len stable until req_ready. Deasserting before grant is legal.
// - Simultaneous requests: round-robin is fair; each requester waits at most N_REQ-1 jobs.
// - acc_owner = owner while acc_busy, else 0. acc_busy=1 in every non-idle state, including S_CPL.
// CONFIGURATION
// - TREES_SCHED_TIMEOUT_EN defined: a watchdog counts cycles in S_RUN, cleared on entry.
//   - When the count reaches TIMEOUT_CYCLES without acc_done: go to S_CPL with err=1.
//   - A late acc_done is ignored.
// - Not defined: no counter is built; S_RUN waits indefinitely; cmp_err comes only from the length check.
// TESTING
// - Single job: req_valid[1]=1, len=16, acc_done 40 cycles after acc_start
//   -> req_ready[1] at t+1, acc_start at t+2, acc_burst_len=16, cmp_valid[1]=1, cmp_err=0, held until cmp_ack[1].
// - Contention: req_valid=4'b1111 all held after reset -> grant order 0,1,2,3,0.
//   Exactly one acc_start per job; acc_owner matches the grant each time.
// - Boundary: len=0 -> req_ready then cmp_valid, no acc_start.
//   len=5001 -> cmp_err=1, no acc_start. len=5000 -> acc_start issued.
// - Ack gating: hold cmp_ack=0 for 100 cycles while req_valid[2]=1
//   -> acc_busy=1, no req_ready[2] until cmp_ack[owner]. A stray cmp_ack on another bit changes nothing.
// - Reset mid-RUN: assert rst for 1 cycle -> all outputs 0 the next cycle. A subsequent req_valid[3]
//   is granted normally; a late acc_done produces no cmp_valid.
// - With TREES_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, no acc_done -> cmp_err=1 after 64 cycles in RUN.
//   Without the macro -> still in S_RUN after 1000 cycles.

Source files
------------

// File: rtl/trees_job_scheduler.sv
// trees_job_scheduler: round-robin job arbiter that shares one trees_ping_pong
// inference engine between N_REQ host requesters and holds ownership until the
// owner acknowledges completion.
// Optional feature macro: TREES_SCHED_TIMEOUT_EN (RUN-state watchdog, err on expiry).
module trees_job_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 5000,
`ifdef TREES_SCHED_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 2**20,
`endif
  localparam int unsigned BL_W = $clog2(MAX_BURST) + 1,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BL_W-1:0]   req_burst_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        cmp_valid,
  output logic                    cmp_err,
  input  logic [N_REQ-1:0]        cmp_ack,
  output logic                    acc_start,
  output logic [BL_W-2:0]         acc_burst_len,
  input  logic                    acc_done,
  output logic                    acc_busy,
  output logic [ID_W-1:0]         acc_owner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_CPL   = 3'd4
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_last;
  logic [BL_W-1:0] len;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] scan_idx;
  logic [BL_W-1:0] gnt_len;

`ifdef TREES_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;
`endif

  // Round-robin pick: first active request scanning upward from rr_last+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_last) + k) % N_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    gnt_len = req_burst_len[32'(gnt_idx)*BL_W +: BL_W];
  end

  // Job sequencer; acc_owner doubles as the owner register for the whole job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_last       <= ID_W'(N_REQ - 1);
      len           <= '0;
      req_ready     <= '0;
      cmp_valid     <= '0;
      cmp_err       <= 1'b0;
      acc_start     <= 1'b0;
      acc_burst_len <= '0;
      acc_busy      <= 1'b0;
      acc_owner     <= '0;
`ifdef TREES_SCHED_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            state         <= S_GRANT;
            acc_owner     <= gnt_idx;
            len           <= gnt_len;
            acc_burst_len <= gnt_len[BL_W-2:0];
            acc_busy      <= 1'b1;
            req_ready     <= N_REQ'(1) << gnt_idx;
          end
        end
        S_GRANT: begin
          req_ready <= '0;
          if (len == '0) begin
            state     <= S_CPL;
            cmp_valid <= N_REQ'(1) << acc_owner;
            cmp_err   <= 1'b0;
          end else if (len > BL_W'(MAX_BURST)) begin
            state     <= S_CPL;
            cmp_valid <= N_REQ'(1) << acc_owner;
            cmp_err   <= 1'b1;
          end else begin
            state     <= S_START;
            acc_start <= 1'b1;
          end
        end
        S_START: begin
          acc_start <= 1'b0;
          state     <= S_RUN;
`ifdef TREES_SCHED_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
        end
        S_RUN: begin
          if (acc_done) begin
            state     <= S_CPL;
            cmp_valid <= N_REQ'(1) << acc_owner;
            cmp_err   <= 1'b0;
          end
`ifdef TREES_SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_CPL;
            cmp_valid <= N_REQ'(1) << acc_owner;
            cmp_err   <= 1'b1;
          end else begin
            wd_cnt    <= wd_cnt + WD_W'(1);
          end
`endif
        end
        S_CPL: begin
          if (cmp_ack[acc_owner]) begin
            state         <= S_IDLE;
            rr_last       <= acc_owner;
            cmp_valid     <= '0;
            cmp_err       <= 1'b0;
            acc_busy      <= 1'b0;
            acc_owner     <= '0;
            acc_burst_len <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trees_job_scheduler.sv
// Directed self-checking bench for trees_job_scheduler (N_REQ=4, MAX_BURST=5000).
module tb_trees_job_scheduler;

  localparam int unsigned N    = 4;
  localparam int unsigned BL_W = 14;
  localparam int unsigned ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*BL_W-1:0] req_burst_len;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      cmp_valid;
  logic              cmp_err;
  logic [N-1:0]      cmp_ack;
  logic              acc_start;
  logic [BL_W-2:0]   acc_burst_len;
  logic              acc_done;
  logic              acc_busy;
  logic [ID_W-1:0]   acc_owner;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;

  trees_job_scheduler #(
    .N_REQ(4),
    .MAX_BURST(5000)
`ifdef TREES_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_burst_len(req_burst_len),
    .req_ready(req_ready),
    .cmp_valid(cmp_valid),
    .cmp_err(cmp_err),
    .cmp_ack(cmp_ack),
    .acc_start(acc_start),
    .acc_burst_len(acc_burst_len),
    .acc_done(acc_done),
    .acc_busy(acc_busy),
    .acc_owner(acc_owner)
  );

  always #5 clk = ~clk;

  // Count accelerator start pulses, sampled mid-cycle.
  always @(negedge clk) if (!rst && acc_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int l);
    req_burst_len[i*BL_W +: BL_W] = BL_W'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (req_ready == '0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_cmp(input int budget);
    int n = 0;
    while (cmp_valid == '0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Drive one job from grant to acknowledged completion.
  task automatic serve(input string tag, input int idx, input int len,
                       input bit exp_start, input bit exp_err, input bit drop,
                       input int done_dly);
    int s0;
    wait_ready(20);
    check({tag, " ready"}, 32'(req_ready), 32'(1 << idx));
    check({tag, " owner"}, 32'(acc_owner), 32'(idx));
    check({tag, " busy"}, 32'(acc_busy), 32'd1);
    if (drop) req_valid[ID_W'(idx)] = 1'b0;
    s0 = start_cnt;
    if (exp_start) begin
      tick();
      check({tag, " start"}, 32'(acc_start), 32'd1);
      check({tag, " blen"}, 32'(acc_burst_len), 32'(len));
      repeat (done_dly) tick();
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
    end
    wait_cmp(20);
    check({tag, " cmp_valid"}, 32'(cmp_valid), 32'(1 << idx));
    check({tag, " cmp_err"}, 32'(cmp_err), 32'(exp_err));
    check({tag, " starts"}, 32'(start_cnt - s0), 32'(exp_start));
    repeat (3) tick();
    check({tag, " held"}, 32'(cmp_valid), 32'(1 << idx));
    cmp_ack[ID_W'(idx)] = 1'b1;
    tick();
    cmp_ack = '0;
    check({tag, " cmp_drop"}, 32'(cmp_valid), 32'd0);
    check({tag, " idle"}, 32'({acc_busy, acc_owner}), 32'd0);
  endtask

  initial begin
    bit bad;
    rst           = 1'b1;
    req_valid     = '0;
    req_burst_len = '0;
    cmp_ack       = '0;
    acc_done      = 1'b0;
    do_reset();
    check("reset outs", 32'({req_ready, cmp_valid, cmp_err, acc_start, acc_busy, acc_owner}), 32'd0);
    check("reset blen", 32'(acc_burst_len), 32'd0);

    // Single job with exact grant/start latency.
    set_len(1, 16);
    req_valid[1] = 1'b1;
    tick();
    check("lat ready", 32'(req_ready), 32'h2);
    serve("single", 1, 16, 1'b1, 1'b0, 1'b1, 40);

    // Length boundaries.
    set_len(2, 0);    req_valid[2] = 1'b1; serve("len0", 2, 0, 1'b0, 1'b0, 1'b1, 0);
    set_len(3, 5001); req_valid[3] = 1'b1; serve("len5001", 3, 5001, 1'b0, 1'b1, 1'b1, 0);
    set_len(1, 5000); req_valid[1] = 1'b1; serve("len5000", 1, 5000, 1'b1, 1'b0, 1'b1, 3);

    // Contention: all four held from reset, expect 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_len(i, 3 + i);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) serve("rr", j % 4, 3 + (j % 4), 1'b1, 1'b0, 1'b0, 2);
    req_valid = '0;
    tick();

    // Ack gating: owner 0 holds completion while requester 2 waits.
    do_reset();
    set_len(0, 0);
    set_len(2, 7);
    req_valid = 4'b0101;
    tick();
    check("gate ready0", 32'(req_ready), 32'h1);
    req_valid[0] = 1'b0;
    tick();
    check("gate cmp", 32'(cmp_valid), 32'h1);
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cmp_ack = (c < 50) ? 4'b0100 : 4'b0000;
      tick();
      if (req_ready != '0 || !acc_busy || cmp_valid != 4'b0001) bad = 1'b1;
    end
    check("gate hold", 32'(bad), 32'd0);
    cmp_ack = 4'b0001;
    tick();
    cmp_ack = '0;
    check("gate drop", 32'({cmp_valid, req_ready}), 32'd0);
    tick();
    check("gate regrant", 32'(req_ready), 32'h4);
    serve("gate2", 2, 7, 1'b1, 1'b0, 1'b1, 5);

    // Reset in RUN abandons the job; late done is ignored.
    set_len(1, 9);
    req_valid[1] = 1'b1;
    wait_ready(20);
    req_valid[1] = 1'b0;
    repeat (5) tick();
    check("pre-rst busy", 32'(acc_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst outs", 32'({req_ready, cmp_valid, cmp_err, acc_start, acc_busy, acc_owner}), 32'd0);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    tick();
    check("late done", 32'({cmp_valid, acc_busy}), 32'd0);
    set_len(3, 2);
    req_valid[3] = 1'b1;
    serve("post-rst", 3, 2, 1'b1, 1'b0, 1'b1, 3);

    // Watchdog behaviour with no acc_done.
    set_len(0, 10);
    req_valid[0] = 1'b1;
    wait_ready(20);
    req_valid[0] = 1'b0;
    tick();
    check("wd start", 32'(acc_start), 32'd1);
`ifdef TREES_SCHED_TIMEOUT_EN
    tick();
    repeat (63) tick();
    check("wd early", 32'(cmp_valid), 32'd0);
    tick();
    check("wd cmp", 32'(cmp_valid), 32'h1);
    check("wd err", 32'(cmp_err), 32'd1);
`else
    repeat (1000) tick();
    check("nowd run", 32'({acc_busy, cmp_valid}), 32'h10);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    wait_cmp(5);
    check("nowd cmp", 32'(cmp_valid), 32'h1);
    check("nowd err", 32'(cmp_err), 32'd0);
`endif
    cmp_ack = 4'b0001;
    tick();
    cmp_ack = '0;
    check("wd idle", 32'({acc_busy, cmp_valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
